ps2_tx_multi: RTL and testbench
===============================

Name: ps2_tx_multi

Overview:
- Parametrised successor to the per-device PS/2 emulation transmitters used for keyboard and mouse.
- Provides CHANNELS independent device-to-host PS/2 serialisers; each has its own byte FIFO of depth 2^FIFO_BITS and all share one PS/2 clock divider.
- Fed from the clk_sys domain by the SPI command decoder (one write strobe per channel).
- Adds full/empty status, sticky overflow flags and an optional host-inhibit abort/retransmit.

Parameters:
CHANNELS, 2, number of independent PS/2 transmit channels (1..8)
FIFO_BITS, 3, log2 of per-channel FIFO depth (1..6)
PS2DIV, 100, internal PS/2 clock half-period in clk_sys cycles (>=2)

Ports:
clk_sys  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
wr_en  in  CHANNELS  per-channel push strobe, one cycle per byte
wr_data  in  8  byte pushed into every channel whose wr_en bit is set
clr_overflow  in  CHANNELS  per-channel clear of the sticky overflow flag
fifo_full  out  CHANNELS  channel FIFO holds 2^FIFO_BITS bytes
fifo_empty  out  CHANNELS  channel FIFO holds 0 bytes
overflow  out  CHANNELS  sticky: a push was dropped because the FIFO was full
busy  out  CHANNELS  channel state != IDLE
ps2_clk  out  CHANNELS  emulated PS/2 clock, idle high
ps2_data  out  CHANNELS  emulated PS/2 data, idle high
ps2_clk_in  in  CHANNELS  sensed PS/2 clock line (used only with PS2_INHIBIT_EN)

Behaviour:
- Reset (async, reset_n low):
  - All FIFO pointers 0; fifo_empty all 1; fifo_full 0; overflow 0; busy 0.
  - Divider counter 0; internal clk_ps2 0; every channel in IDLE.
  - ps2_data all 1; ps2_clk all 1.
  - Reset asserted mid-frame abandons the frame and empties all FIFOs.
- Divider:
  - Counter runs 0..PS2DIV-1.
  - At PS2DIV-1 it returns to 0 and clk_ps2 toggles.
  - tick = one-cycle pulse on the cycle clk_ps2 goes 0->1, so one tick every 2*PS2DIV cycles.
- FIFO (per channel):
  - Pointers are FIFO_BITS+1 wide. full = MSBs differ and LSBs are equal; empty = pointers equal.
  - Push when wr_en[ch] and !full: store the byte and increment wptr in the same cycle.
  - Push when full: byte dropped, wptr unchanged, overflow[ch] set next cycle.
  - A push and a pop in the same cycle are both performed; the push is judged against the pre-pop full flag.
  - clr_overflow[ch] clears the flag. If a clear and a new overflow occur in the same cycle, the overflow wins (flag stays 1).
- Transmit FSM (per channel); all transitions on tick only:
  - IDLE(0): if !empty, load shift = fifo[rptr], parity = 1, ps2_data = 0 (start bit), go to 1. Otherwise hold.
  - States 1..8: ps2_data = shift[0]; shift right by one; if shift[0]=1, toggle parity; state+1. Data is sent LSB first.
  - State 9: ps2_data = parity (odd parity over the 8 data bits); go to 10.
  - State 10: ps2_data = 1 (stop bit); go to 11.
  - State 11: pop the FIFO (rptr+1); go to IDLE; ps2_data stays 1.
  - The byte is popped only at frame completion, so fifo_full counts the byte currently being sent.
- ps2_clk[ch] = clk_ps2 | (state == IDLE).
- ps2_data changes only on tick, i.e. while ps2_clk is rising/high; the host samples data on the falling clock edge.
- Frame length: 12 ticks from leaving IDLE to returning to IDLE. Back-to-back bytes leave one IDLE tick between frames.
- Channels are fully independent; only the divider is shared, so frames on different channels are tick-aligned.

Optional Feature:
- Macro PS2_INHIBIT_EN.
- Defined:
  - ps2_clk_in passes through a 2-flop synchroniser per channel.
  - If the synchronised input is 0 while clk_ps2 = 1 and the channel state is 1..10, the host is inhibiting.
  - On the next clk_sys cycle (not waiting for tick): state = IDLE, ps2_data = 1, FIFO not popped. The same byte is retransmitted from the start bit on the first tick after the inhibit clears.
  - While the input is 0, IDLE does not start a new frame.
- Undefined:
  - ps2_clk_in is ignored and left unconnected internally.
  - Frames always complete; there is no synchroniser logic.

Test Plan:
- PS2DIV=4, push 0x1C on ch0 -> ps2_data over successive ticks = 0,0,0,1,1,1,0,0,0,0(parity),1; ps2_clk toggles every 4 cycles during the frame and is held 1 in IDLE; busy high for 12 ticks.
- FIFO_BITS=3, push 9 bytes on ch1 in consecutive cycles with no ticks -> fifo_full after the 8th push, 9th dropped, overflow[1]=1; apply clr_overflow[1] together with a 10th push -> overflow stays 1.
- Push 0xFF on ch0 and 0x00 on ch1 in the same cycle -> both frames tick-aligned; parity bits are 1 (0xFF) and 1 (0x00); channels do not interfere.
- Push 3 bytes 0xAA, 0x55, 0x01 -> three frames in order, one IDLE tick between them; fifo_empty rises on the State 11 tick of frame 3.
- Assert reset_n=0 during state 5 with 2 bytes queued -> ps2_data=1, ps2_clk=1, fifo_empty=1 immediately; nothing transmitted after release.
- PS2_INHIBIT_EN: drive ps2_clk_in=0 for 20 cycles during state 6 of 0x1C -> the frame aborts and fifo_empty stays 0; after release the full 0x1C frame is resent from the start bit.

Source files
------------

// File: rtl/ps2_tx_multi.sv
// Multi-channel PS/2 device-to-host transmitter: per-channel byte FIFO and frame serialiser, shared clock divider.
// Define PS2_INHIBIT_EN to let a host holding ps2_clk_in low abort the current frame, which is then resent.
module ps2_tx_multi #(
    parameter int CHANNELS  = 2,
    parameter int FIFO_BITS = 3,
    parameter int PS2DIV    = 100
) (
    input  logic                clk_sys,
    input  logic                reset_n,
    input  logic [CHANNELS-1:0] wr_en,
    input  logic [7:0]          wr_data,
    input  logic [CHANNELS-1:0] clr_overflow,
    output logic [CHANNELS-1:0] fifo_full,
    output logic [CHANNELS-1:0] fifo_empty,
    output logic [CHANNELS-1:0] overflow,
    output logic [CHANNELS-1:0] busy,
    output logic [CHANNELS-1:0] ps2_clk,
    output logic [CHANNELS-1:0] ps2_data,
    input  logic [CHANNELS-1:0] ps2_clk_in
);

    localparam int DEPTH = 1 << FIFO_BITS;
    localparam int CW    = (PS2DIV > 1) ? $clog2(PS2DIV) : 1;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_B1   = 4'd1,
        ST_B2   = 4'd2,
        ST_B3   = 4'd3,
        ST_B4   = 4'd4,
        ST_B5   = 4'd5,
        ST_B6   = 4'd6,
        ST_B7   = 4'd7,
        ST_B8   = 4'd8,
        ST_PAR  = 4'd9,
        ST_STOP = 4'd10,
        ST_DONE = 4'd11
    } state_t;

    logic [CW-1:0] div_cnt_q, div_cnt_d;
    logic          clk_ps2_q, clk_ps2_d;
    logic          tick;

    always_comb begin
        div_cnt_d = div_cnt_q + CW'(1);
        clk_ps2_d = clk_ps2_q;
        if (div_cnt_q == CW'(PS2DIV - 1)) begin
            div_cnt_d = '0;
            clk_ps2_d = ~clk_ps2_q;
        end
    end

    // Every serialiser advances on the rising edge of the shared PS/2 clock.
    assign tick = (div_cnt_q == CW'(PS2DIV - 1)) && !clk_ps2_q;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt_q <= '0;
            clk_ps2_q <= 1'b0;
        end else begin
            div_cnt_q <= div_cnt_d;
            clk_ps2_q <= clk_ps2_d;
        end
    end

`ifndef PS2_INHIBIT_EN
    logic unused_clk_in;
    assign unused_clk_in = ^ps2_clk_in;
`endif

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [FIFO_BITS:0] wptr_q, wptr_d, rptr_q, rptr_d;
            logic [7:0]         mem_q [DEPTH];
            state_t             state_q, state_d;
            logic [7:0]         shift_q, shift_d;
            logic               parity_q, parity_d;
            logic               data_q, data_d;
            logic               ovf_q, ovf_d;
            logic               full, empty, push, pop;
            logic               host_low, abort;

            assign empty = (wptr_q == rptr_q);
            assign full  = (wptr_q[FIFO_BITS] != rptr_q[FIFO_BITS]) &&
                           (wptr_q[FIFO_BITS-1:0] == rptr_q[FIFO_BITS-1:0]);
            assign push  = wr_en[gi] && !full;

`ifdef PS2_INHIBIT_EN
            logic [1:0] sync_q;
            always_ff @(posedge clk_sys or negedge reset_n) begin
                if (!reset_n) begin
                    sync_q <= 2'b11;
                end else begin
                    sync_q <= {sync_q[0], ps2_clk_in[gi]};
                end
            end
            assign host_low = !sync_q[1];
            // The host can only pull the clock low while we are driving it high.
            assign abort    = host_low && clk_ps2_q &&
                              (state_q != ST_IDLE) && (state_q != ST_DONE);
`else
            assign host_low = 1'b0;
            assign abort    = 1'b0;
`endif

            always_comb begin
                state_d  = state_q;
                shift_d  = shift_q;
                parity_d = parity_q;
                data_d   = data_q;
                pop      = 1'b0;
                if (abort) begin
                    state_d = ST_IDLE;
                    data_d  = 1'b1;
                end else if (tick) begin
                    case (state_q)
                        ST_IDLE: begin
                            if (!empty && !host_low) begin
                                shift_d  = mem_q[rptr_q[FIFO_BITS-1:0]];
                                parity_d = 1'b1;
                                data_d   = 1'b0;
                                state_d  = ST_B1;
                            end
                        end
                        ST_B1, ST_B2, ST_B3, ST_B4, ST_B5, ST_B6, ST_B7, ST_B8: begin
                            data_d  = shift_q[0];
                            shift_d = {1'b0, shift_q[7:1]};
                            if (shift_q[0]) begin
                                parity_d = ~parity_q;
                            end
                            state_d = state_t'(state_q + 4'd1);
                        end
                        ST_PAR: begin
                            data_d  = parity_q;
                            state_d = ST_STOP;
                        end
                        ST_STOP: begin
                            data_d  = 1'b1;
                            state_d = ST_DONE;
                        end
                        ST_DONE: begin
                            // Pop only once the frame is fully on the wire.
                            pop     = 1'b1;
                            state_d = ST_IDLE;
                        end
                        default: begin
                            data_d  = 1'b1;
                            state_d = ST_IDLE;
                        end
                    endcase
                end
            end

            assign wptr_d = wptr_q + {{FIFO_BITS{1'b0}}, push};
            assign rptr_d = rptr_q + {{FIFO_BITS{1'b0}}, pop};
            // A drop outranks a simultaneous clear.
            assign ovf_d  = (wr_en[gi] && full) ? 1'b1 :
                            clr_overflow[gi]    ? 1'b0 : ovf_q;

            always_ff @(posedge clk_sys) begin
                if (push) begin
                    mem_q[wptr_q[FIFO_BITS-1:0]] <= wr_data;
                end
            end

            always_ff @(posedge clk_sys or negedge reset_n) begin
                if (!reset_n) begin
                    wptr_q   <= '0;
                    rptr_q   <= '0;
                    state_q  <= ST_IDLE;
                    shift_q  <= '0;
                    parity_q <= 1'b1;
                    data_q   <= 1'b1;
                    ovf_q    <= 1'b0;
                end else begin
                    wptr_q   <= wptr_d;
                    rptr_q   <= rptr_d;
                    state_q  <= state_d;
                    shift_q  <= shift_d;
                    parity_q <= parity_d;
                    data_q   <= data_d;
                    ovf_q    <= ovf_d;
                end
            end

            assign fifo_full[gi]  = full;
            assign fifo_empty[gi] = empty;
            assign overflow[gi]   = ovf_q;
            assign busy[gi]       = (state_q != ST_IDLE);
            assign ps2_clk[gi]    = clk_ps2_q | (state_q == ST_IDLE);
            assign ps2_data[gi]   = data_q;
        end
    endgenerate

endmodule

// File: tb/tb_ps2_tx_multi.sv
// Directed bench for ps2_tx_multi with PS2DIV=4: a tick lands on edge 4 after reset and every 8 edges after that.
module tb_ps2_tx_multi;

    localparam int CH = 2;

    logic          clk_sys = 1'b0;
    logic          reset_n = 1'b0;
    logic [CH-1:0] wr_en = '0;
    logic [7:0]    wr_data = '0;
    logic [CH-1:0] clr_overflow = '0;
    logic [CH-1:0] fifo_full, fifo_empty, overflow, busy, ps2_clk, ps2_data;
    logic [CH-1:0] ps2_clk_in = '1;

    int total = 0;
    int bad   = 0;
    int ecnt  = 0;

    // Expected ps2_data on frame ticks 1..12, tick 1 in the MSB.
    logic [11:0] f_1c = 12'b000111000011;
    logic [11:0] f_aa = 12'b001010101111;
    logic [11:0] f_55 = 12'b010101010111;
    logic [11:0] f_01 = 12'b010000000011;
    logic [11:0] f_ff = 12'b011111111111;
    logic [11:0] f_00 = 12'b000000000111;
    logic [11:0] fr [3];

    ps2_tx_multi #(.CHANNELS(CH), .FIFO_BITS(3), .PS2DIV(4)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .wr_en(wr_en), .wr_data(wr_data),
        .clr_overflow(clr_overflow), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .overflow(overflow), .busy(busy), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .ps2_clk_in(ps2_clk_in)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk_sys);
        ecnt++;
        #1;
    endtask

    task automatic next_tick();
        do begin
            @(posedge clk_sys);
            ecnt++;
        end while ((ecnt % 8) != 4);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        wr_en = '0;
        clr_overflow = '0;
        ps2_clk_in = '1;
        repeat (2) @(posedge clk_sys);
        #1;
        reset_n = 1'b1;
        ecnt = 0;
    endtask

    task automatic push(input logic [CH-1:0] en, input logic [7:0] d);
        wr_en = en;
        wr_data = d;
        cycle();
        wr_en = '0;
    endtask

    initial begin
        // Reset state
        do_reset();
        chk("rst_empty", 8'(fifo_empty), 8'h03);
        chk("rst_full", 8'(fifo_full), 8'h00);
        chk("rst_ovf", 8'(overflow), 8'h00);
        chk("rst_busy", 8'(busy), 8'h00);
        chk("rst_clk", 8'(ps2_clk), 8'h03);
        chk("rst_data", 8'(ps2_data), 8'h03);

        // Single 0x1C frame on ch0 with clock shape
        push(2'b01, 8'h1C);
        chk("t1_empty_after_push", 8'(fifo_empty), 8'h02);
        for (int i = 0; i < 12; i++) begin
            next_tick();
            chk($sformatf("t1_data_tick%0d", i + 1), 8'(ps2_data[0]), 8'(f_1c[11 - i]));
            chk($sformatf("t1_busy_tick%0d", i + 1), 8'(busy[0]), 8'(i < 11));
            chk($sformatf("t1_clkhi_tick%0d", i + 1), 8'(ps2_clk[0]), 8'h01);
            chk($sformatf("t1_ch1_idle%0d", i + 1), 8'(ps2_data[1]), 8'h01);
            repeat (4) cycle();
            chk($sformatf("t1_clkmid_tick%0d", i + 1), 8'(ps2_clk[0]), 8'(i >= 11));
        end
        chk("t1_empty_end", 8'(fifo_empty[0]), 8'h01);

        // Fill ch1, overflow, clear racing a drop, then plain clear
        do_reset();
        for (int k = 1; k <= 9; k++) begin
            push(2'b10, 8'(8'h10 + k));
            if (k == 7) chk("t2_full_at7", 8'(fifo_full), 8'h00);
            if (k == 8) begin
                chk("t2_full_at8", 8'(fifo_full), 8'h02);
                chk("t2_ovf_at8", 8'(overflow), 8'h00);
            end
            if (k == 9) chk("t2_ovf_at9", 8'(overflow), 8'h02);
        end
        wr_en = 2'b10;
        clr_overflow = 2'b10;
        cycle();
        wr_en = '0;
        chk("t2_ovf_clr_race", 8'(overflow), 8'h02);
        cycle();
        clr_overflow = '0;
        chk("t2_ovf_cleared", 8'(overflow), 8'h00);
        chk("t2_still_full", 8'(fifo_full), 8'h02);
        chk("t2_empty", 8'(fifo_empty), 8'h01);

        // 0xFF on ch0 and 0x00 on ch1, tick-aligned frames
        do_reset();
        push(2'b01, 8'hFF);
        push(2'b10, 8'h00);
        for (int i = 0; i < 12; i++) begin
            next_tick();
            chk($sformatf("t3_ch0_tick%0d", i + 1), 8'(ps2_data[0]), 8'(f_ff[11 - i]));
            chk($sformatf("t3_ch1_tick%0d", i + 1), 8'(ps2_data[1]), 8'(f_00[11 - i]));
            chk($sformatf("t3_busy_tick%0d", i + 1), 8'(busy), (i < 11) ? 8'h03 : 8'h00);
        end

        // Three queued bytes, back to back
        do_reset();
        push(2'b01, 8'hAA);
        push(2'b01, 8'h55);
        push(2'b01, 8'h01);
        fr[0] = f_aa;
        fr[1] = f_55;
        fr[2] = f_01;
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 12; i++) begin
                next_tick();
                chk($sformatf("t4_f%0d_tick%0d", f, i + 1), 8'(ps2_data[0]), 8'(fr[f][11 - i]));
                chk($sformatf("t4_f%0d_busy%0d", f, i + 1), 8'(busy[0]), 8'(i < 11));
                chk($sformatf("t4_f%0d_empty%0d", f, i + 1), 8'(fifo_empty[0]), 8'(f == 2 && i == 11));
            end
        end

        // Reset in the middle of a frame with two bytes queued
        do_reset();
        push(2'b01, 8'h1C);
        push(2'b01, 8'h33);
        for (int i = 0; i < 5; i++) begin
            next_tick();
            chk($sformatf("t5_data_tick%0d", i + 1), 8'(ps2_data[0]), 8'(f_1c[11 - i]));
        end
        cycle();
        cycle();
        reset_n = 1'b0;
        #1;
        chk("t5_rst_data", 8'(ps2_data), 8'h03);
        chk("t5_rst_clk", 8'(ps2_clk), 8'h03);
        chk("t5_rst_empty", 8'(fifo_empty), 8'h03);
        chk("t5_rst_busy", 8'(busy), 8'h00);
        do_reset();
        for (int i = 0; i < 14; i++) begin
            next_tick();
            chk($sformatf("t5_quiet_data%0d", i), 8'(ps2_data), 8'h03);
            chk($sformatf("t5_quiet_busy%0d", i), 8'(busy), 8'h00);
        end

`ifdef PS2_INHIBIT_EN
        // Host inhibit during state 6, then full resend
        do_reset();
        push(2'b01, 8'h1C);
        for (int i = 0; i < 6; i++) begin
            next_tick();
            chk($sformatf("t6_pre_tick%0d", i + 1), 8'(ps2_data[0]), 8'(f_1c[11 - i]));
        end
        ps2_clk_in[0] = 1'b0;
        repeat (3) cycle();
        chk("t6_abort_busy", 8'(busy[0]), 8'h00);
        chk("t6_abort_data", 8'(ps2_data[0]), 8'h01);
        chk("t6_abort_empty", 8'(fifo_empty[0]), 8'h00);
        next_tick();
        chk("t6_hold_busy", 8'(busy[0]), 8'h00);
        while (ecnt < 64) cycle();
        ps2_clk_in[0] = 1'b1;
        for (int i = 0; i < 12; i++) begin
            next_tick();
            chk($sformatf("t6_resend_tick%0d", i + 1), 8'(ps2_data[0]), 8'(f_1c[11 - i]));
            chk($sformatf("t6_resend_empty%0d", i + 1), 8'(fifo_empty[0]), 8'(i == 11));
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
